// File: rtl/step_pkg.sv
// step_pkg: shared types and widths for the step controller.
//   step_state_t : controller state encoding
//   STEP_CNT_W   : width of the issued-step statistics counter
//   OVR_CNT_W    : width of the saturating dropped-request counter
package step_pkg;

  localparam int STEP_CNT_W = 16;
  localparam int OVR_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_ISSUE = 3'd3,
    DONE       = 3'd4
  } step_state_t;

endpackage

// File: rtl/step_ctrl_rise_detect.sv
// rise_detect: registers a level input and flags its rising edge.
//   clk  : system clock
//   aclr : asynchronous active-high reset (history cleared to 0)
//   d    : level input
//   rise : high for the cycle in which d is 1 and was 0 last cycle
module rise_detect (
  input  logic clk,
  input  logic aclr,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; a blocking = here would race with its readers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: turns step-unit mode/pulse levels into a single pipeline
// advance enable for the bilinear downscaling datapath.
//   clk, aclr       : clock, asynchronous active-high reset
//   step_mode       : 1 = step-by-step, 0 = free-run
//   step_pulse      : manual step level; its rising edge is a request
//   auto_step_pulse : auto-step request level
//   start           : one-cycle frame start (honoured in IDLE only)
//   frame_done      : one-cycle end-of-frame from the pipeline
//   pipe_ready      : pipeline can accept an advance this cycle
//   pipe_en         : pipeline advance enable
//   step_ack        : one-cycle acknowledge of each issued step
//   busy            : high in RUN, STEP_WAIT and STEP_ISSUE
//   done            : one-cycle frame-complete strobe
//   step_count      : steps issued since start
//   overrun_count   : dropped step requests, saturating
// Build option: define STEP_CTRL_STATS_EN to implement the two statistics
// counters; without it both outputs are tied to 0.
module step_ctrl
  import step_pkg::*;
(
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  step_mode,
  input  logic                  step_pulse,
  input  logic                  auto_step_pulse,
  input  logic                  start,
  input  logic                  frame_done,
  input  logic                  pipe_ready,
  output logic                  pipe_en,
  output logic                  step_ack,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic [OVR_CNT_W-1:0]  overrun_count
);

  step_state_t state_q;
  logic        pending_q;
  logic        rise;

  rise_detect u_rise_detect (
    .clk  (clk),
    .aclr (aclr),
    .d    (step_pulse),
    .rise (rise)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pending_q <= 1'b0;
            state_q   <= step_mode ? STEP_WAIT : RUN;
          end
        end
        RUN: begin
          if (frame_done)     state_q <= DONE;
          else if (step_mode) state_q <= STEP_WAIT;
        end
        STEP_WAIT: begin
          // frame_done wins over any step request arriving the same cycle.
          if (frame_done) begin
            state_q <= DONE;
          end else if (!step_mode) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
          end else if ((pending_q | rise | auto_step_pulse) & pipe_ready) begin
            state_q <= STEP_ISSUE;
          end else if (rise) begin
            pending_q <= 1'b1;
          end
        end
        STEP_ISSUE: begin
          // The issue consumes pending; a fresh edge now queues the next step.
          pending_q <= rise;
          state_q   <= frame_done ? DONE : STEP_WAIT;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode state only, except pipe_en in RUN which follows
  // pipe_ready in the same cycle so free-run loses no throughput.
  assign step_ack = (state_q == STEP_ISSUE);
  assign done     = (state_q == DONE);
  assign busy     = (state_q == RUN) | (state_q == STEP_WAIT) | (state_q == STEP_ISSUE);
  assign pipe_en  = ((state_q == RUN) & pipe_ready) | step_ack;

`ifdef STEP_CTRL_STATS_EN
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [OVR_CNT_W-1:0]  ovr_cnt_q,  ovr_cnt_d;
  logic                  ovr_event;

  // A new edge that finds a request already queued is dropped.
  assign ovr_event = (state_q == STEP_WAIT) & ~frame_done & step_mode & rise & pending_q;

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    step_cnt_d = step_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    if ((state_q == IDLE) && start) begin
      step_cnt_d = '0;
      ovr_cnt_d  = '0;
    end else begin
      if (state_q == STEP_ISSUE)        step_cnt_d = step_cnt_q + 1'b1;
      if (ovr_event && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      step_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign step_count    = step_cnt_q;
  assign overrun_count = ovr_cnt_q;
`else
  assign step_count    = '0;
  assign overrun_count = '0;
`endif

endmodule
